// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-ported data memory between the CPU (port 0) and a second master (port 1).
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default build is round-robin.
module dmem_arbiter #(
  parameter int   ADDR_W     = 9,
  parameter int   DATA_W     = 16,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ACK0, ACK1} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   pick1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= RESET_LAST;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        GRANT0: begin
          last <= 1'b0;
          if (!r0_rw) r0_rdata <= mem_rdata;
        end
        GRANT1: begin
          last <= 1'b1;
          if (!r1_rw) r1_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    pick1          = 1'b0;
    mem_read_write = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    r0_ack         = 1'b0;
    r1_ack         = 1'b0;
    case (state)
      IDLE: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick1 = r1_req && !r0_req;
`else
        pick1 = r1_req && (!r0_req || !last);
`endif
        if (r0_req || r1_req) state_nxt = pick1 ? GRANT1 : GRANT0;
      end
      // Memory bus is zeroed while reset is high so an interrupted grant never commits a write.
      GRANT0: begin
        if (!reset) begin
          mem_read_write = r0_rw;
          mem_addr       = r0_addr;
          mem_wdata      = r0_wdata;
        end
        state_nxt = ACK0;
      end
      GRANT1: begin
        if (!reset) begin
          mem_read_write = r1_rw;
          mem_addr       = r1_addr;
          mem_wdata      = r1_wdata;
        end
        state_nxt = ACK1;
      end
      ACK0: begin
        r0_ack    = !reset;
        state_nxt = IDLE;
      end
      ACK1: begin
        r1_ack    = !reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-ported data memory between the CPU (port 0) and a second bus master (port 1: DMA / debug loader).
- Sits between the requesters and the data memory.
- Serialises accesses and issues a one-cycle acknowledge per completed access.
- Guarantees no spurious memory writes when idle or in reset.

Parameters:
- ADDR_W, 9, data memory address width.
- DATA_W, 16, data word width.
- RESET_LAST, 1, last-granted port after reset; with the default, port 0 wins the first tie.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- r0_req  input  1  port 0 access request; level, held until r0_ack.
- r0_rw  input  1  port 0 direction: 1 = write, 0 = read.
- r0_addr  input  ADDR_W  port 0 address.
- r0_wdata  input  DATA_W  port 0 write data.
- r0_ack  output  1  port 0 access complete; one-cycle pulse.
- r0_rdata  output  DATA_W  port 0 read data; valid while r0_ack=1 and for reads only.
- r1_req, r1_rw, r1_addr, r1_wdata, r1_ack, r1_rdata: same as port 0, for port 1.
- mem_read_write  output  1  to data memory: 1 = write.
- mem_addr  output  ADDR_W  to data memory.
- mem_wdata  output  DATA_W  to data memory.
- mem_rdata  input  DATA_W  from data memory; combinational read of mem_addr.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = IDLE, last = RESET_LAST.
  - r0_ack = r1_ack = 0; r0_rdata = r1_rdata = 0.
  - mem_read_write = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE, GRANT0, GRANT1, ACK0, ACK1.
- IDLE:
  - Memory outputs = 0; mem_read_write = 0.
  - Only r0_req -> GRANT0; only r1_req -> GRANT1.
  - Both requesting -> grant the port that is not `last`.
  - Neither requesting -> stay in IDLE.
- GRANTx:
  - Memory outputs are driven combinationally from port x: mem_read_write = rx_rw, mem_addr = rx_addr, mem_wdata = rx_wdata.
  - At the closing edge: a write commits in memory; rx_rdata <= mem_rdata if rx_rw = 0, otherwise it holds its previous value.
  - At the same edge: last <= x, state -> ACKx.
- ACKx:
  - rx_ack = 1 for exactly this cycle; memory outputs = 0.
  - Next edge -> IDLE.
- Latency: request sampled high at edge N (in IDLE) -> GRANT during cycle N+1 -> ack during cycle N+2. Throughput is one access per 3 cycles.
- Requester rules:
  - req, rw, addr and wdata stay stable from assertion until the ack cycle.
  - In the cycle after ack, req is low or carries a new request; a held req is treated as a new request.
- Request withdrawn while in GRANTx: the access still completes and the ack is still issued. Withdrawing is a protocol violation; the bench flags it but the RTL does not guard against it.
- Simultaneous requests: round-robin, so back-to-back contention alternates 0,1,0,1.
- The non-granted port's request stays pending, unacknowledged, and is served next.
- Reset mid-operation:
  - Reset high during GRANTx forces mem_read_write = 0 combinationally that cycle, so no write commits.
  - Next state = IDLE; no ack is issued and rdata is reset.
  - The aborted request is not replayed automatically; a requester still holding req is re-arbitrated after reset.
- Width rules: addresses and data pass through unmodified; no truncation or extension.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 (CPU) always wins a tie and `last` is ignored for arbitration (still updated).
- Undefined: round-robin as above.

Test Plan:
- Port 0 write: addr 0x005, wdata 0xBEEF; then port 0 read of 0x005 -> write ack 2 cycles after req sampled; read ack returns r0_rdata = 0xBEEF.
- Simultaneous requests from reset: r0 read 0x010, r1 write 0x010 = 0x1234, both held -> port 0 acked first with the old value; port 1 acked 3 cycles later; memory 0x010 = 0x1234.
- Both ports requesting continuously for 6 accesses -> grant order 0,1,0,1,0,1; with DMEM_ARB_FIXED_PRIO_EN, port 1 is starved while port 0 keeps requesting.
- Idle with no requests for 20 cycles -> mem_read_write = 0 every cycle; no acks.
- Reset asserted during GRANT1 for write 0x1FF = 0xAAAA -> mem_read_write = 0 that cycle; 0x1FF unchanged; r1_ack never pulses; state returns to IDLE.
- Address boundary: port 1 write 0x1FF = 0x0001, then read -> 0x0001 returned; no wrap into 0x000.
